mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_timeout_ctr.sv | 28 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified-memory port arbiter: FSM encoding and common words.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StData  = 2'd1,
    StInstr = 2'd2,
    StError = 2'd3
  } state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  function automatic logic is_access(input state_e s);
    return (s == StData) || (s == StInstr);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait counter for an outstanding memory access; flags the TIMEOUT-th cycle without an ack.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Fires while the counter still reads TIMEOUT-1, so the FSM leaves on the edge it would reach TIMEOUT.
  assign expired = enable && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port unified memory.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        port_req,
  output logic        port_we,
  output logic [31:0] port_addr,
  output logic [31:0] port_wdata,
  input  logic        port_ack,
  input  logic [31:0] port_rdata,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic [31:0] mem_rdata,
  output logic        mem_valid,
  output logic        stall_if,
  output logic        stall_pipe,
  output logic        err
);

  state_e      state_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_hold_q;
  logic [31:0] mem_hold_q;

  logic data_pend;
  logic in_data;
  logic in_instr;
  logic ctr_clear;
  logic ctr_en;
  logic expired;

  assign data_pend = mem_read_in | mem_write_in;
  assign in_data   = (state_q == StData);
  assign in_instr  = (state_q == StInstr);
  // Every entry to an access comes from IDLE or from an ack cycle, so clearing there covers all entries.
  assign ctr_clear = (state_q == StIdle) | port_ack;
  assign ctr_en    = is_access(state_q) & ~port_ack;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= ZeroWord;
      wdata_q    <= ZeroWord;
      if_hold_q  <= ZeroWord;
      mem_hold_q <= ZeroWord;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (data_pend) begin
            state_q <= StData;
            we_q    <= mem_write_in;
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
          end else if (if_req) begin
            state_q <= StInstr;
            we_q    <= 1'b0;
            addr_q  <= if_addr;
          end
        end
        StData: begin
          if (port_ack) begin
            if (!we_q) mem_hold_q <= port_rdata;
            we_q <= 1'b0;
            if (if_req) begin
              state_q <= StInstr;
              addr_q  <= if_addr;
            end else begin
              state_q <= StIdle;
            end
          end else if (expired) begin
            state_q <= StError;
            we_q    <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        StInstr: begin
          if (port_ack) begin
            if_hold_q <= port_rdata;
            if (data_pend) begin
              state_q <= StData;
              we_q    <= mem_write_in;
              addr_q  <= mem_addr;
              wdata_q <= mem_wdata;
            end else begin
              state_q <= StIdle;
            end
          end else if (expired) begin
            state_q <= StError;
            err_q   <= 1'b1;
          end
        end
        StError: state_q <= StError;
        default: state_q <= StError;
      endcase
    end
  end

  always_comb begin
    port_req   = is_access(state_q);
    port_we    = we_q;
    port_addr  = addr_q;
    port_wdata = wdata_q;
    mem_valid  = in_data & port_ack;
    if_valid   = in_instr & port_ack;
    mem_rdata  = (mem_valid && !we_q) ? port_rdata : mem_hold_q;
    if_rdata   = if_valid ? port_rdata : if_hold_q;
    err        = err_q;
    // Stalls look at live inputs, so reset has to mask them explicitly.
    stall_pipe = ~rst & ((state_q == StError) | (in_data & ~port_ack) | (~in_data & data_pend));
    stall_if   = stall_pipe | (~rst & if_req & ~if_valid);
  end

endmodule
